// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Host-side controller for the FRANK6000 CPU core. It receives a program as
// a byte stream over a valid/ready handshake and packs each pair of bytes
// (big-endian) into one 16-bit instruction word. Each word is written to the
// next location of the CPU instruction memory. The sequencer then pulses the
// CPU reset for one cycle and runs the CPU. The run ends when the CPU raises
// its halt-loop flag or when the cycle budget runs out.
//
// Ports
//   i_clk           clock, rising edge only
//   i_rst           asynchronous active-high reset
//   i_start         begin a load-and-run sequence (honoured in IDLE / DONE)
//   i_abort         force IDLE from any state (beats i_start)
//   i_length        number of words to load, 0..256 (0 = rerun memory as is)
//   i_max_cycles    run budget in cycles, 0 = no timeout
//   i_byte          program byte
//   i_byte_valid    i_byte is valid
//   o_byte_ready    sequencer can take a byte this cycle
//   i_loopf         CPU halt-loop flag
//   o_instr_addr    instruction memory write address
//   o_instr         instruction memory write data
//   o_we            instruction memory write enable (one cycle per word)
//   o_ON            CPU run enable
//   o_cpu_rst       CPU reset pulse
//   o_busy          high in every state except IDLE and DONE
//   o_done          run ended on i_loopf (sticky until start / abort)
//   o_timeout       run ended on the budget (sticky until start / abort)
//   o_cycles        number of RUN cycles elapsed
//
// Every output is a register. Each output is set on the transition into the
// state that needs it.
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH:0]   i_length,
    input  logic [CNT_WIDTH-1:0]  i_max_cycles,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    input  logic                  i_loopf,
    output logic [ADDR_WIDTH-1:0] o_instr_addr,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic                  o_we,
    output logic                  o_ON,
    output logic                  o_cpu_rst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [CNT_WIDTH-1:0]  o_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        WRITE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   length_q;
    logic [CNT_WIDTH-1:0]  budget_q;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   words_written;

    logic [ADDR_WIDTH:0]   words_next;
    logic [CNT_WIDTH-1:0]  cycles_inc;
    logic [CNT_WIDTH-1:0]  cycles_next;
    logic                  budget_hit;
    logic                  loop_seen;

    // The word count has one bit more than the pointer. A 256-word load
    // therefore ends correctly even though the pointer wraps to 0 after the
    // last write. The run counter saturates, so an unlimited run (budget 0)
    // never wraps back to zero. A loopf seen in the first RUN cycle is
    // discarded: that cycle is the fetch-settle cycle after the CPU reset.
    always_comb begin
        words_next  = words_written + (ADDR_WIDTH+1)'(1);
        cycles_inc  = o_cycles + CNT_WIDTH'(1);
        cycles_next = (o_cycles == '1) ? o_cycles : cycles_inc;
        budget_hit  = (budget_q != '0) && (cycles_inc == budget_q);
        loop_seen   = i_loopf && (o_cycles != '0);
    end

    // Main sequencer. Abort has priority over everything except the
    // asynchronous reset. Abort clears all outputs so the host sees a quiet
    // interface, but memory contents already written are left alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            length_q      <= '0;
            budget_q      <= '0;
            wr_ptr        <= '0;
            words_written <= '0;
            o_byte_ready  <= 1'b0;
            o_instr_addr  <= '0;
            o_instr       <= '0;
            o_we          <= 1'b0;
            o_ON          <= 1'b0;
            o_cpu_rst     <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_timeout     <= 1'b0;
            o_cycles      <= '0;
        end else if (i_abort) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            words_written <= '0;
            o_byte_ready  <= 1'b0;
            o_instr_addr  <= '0;
            o_instr       <= '0;
            o_we          <= 1'b0;
            o_ON          <= 1'b0;
            o_cpu_rst     <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_timeout     <= 1'b0;
            o_cycles      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        length_q      <= i_length;
                        budget_q      <= i_max_cycles;
                        wr_ptr        <= '0;
                        words_written <= '0;
                        o_done        <= 1'b0;
                        o_timeout     <= 1'b0;
                        o_cycles      <= '0;
                        o_busy        <= 1'b1;
                        if (i_length == '0) begin
                            // Nothing to load: rerun what is already in memory.
                            state        <= CLEAR;
                            o_cpu_rst    <= 1'b1;
                            o_byte_ready <= 1'b0;
                        end else begin
                            state        <= LOAD_HI;
                            o_byte_ready <= 1'b1;
                        end
                    end
                end

                LOAD_HI: begin
                    if (i_byte_valid) begin
                        o_instr[15:8] <= i_byte;
                        state         <= LOAD_LO;
                    end
                end

                LOAD_LO: begin
                    if (i_byte_valid) begin
                        o_instr[7:0] <= i_byte;
                        o_byte_ready <= 1'b0;
                        o_we         <= 1'b1;
                        o_instr_addr <= wr_ptr;
                        state        <= WRITE;
                    end
                end

                WRITE: begin
                    o_we          <= 1'b0;
                    wr_ptr        <= wr_ptr + ADDR_WIDTH'(1);
                    words_written <= words_next;
                    if (words_next == length_q) begin
                        state     <= CLEAR;
                        o_cpu_rst <= 1'b1;
                    end else begin
                        state        <= LOAD_HI;
                        o_byte_ready <= 1'b1;
                    end
                end

                CLEAR: begin
                    o_cpu_rst <= 1'b0;
                    o_ON      <= 1'b1;
                    state     <= RUN;
                end

                RUN: begin
                    // The last run cycle is counted too, so o_cycles ends
                    // up equal to the number of cycles o_ON was high.
                    // If loopf and the budget end the run together, the
                    // loopf (done) result is the one reported.
                    o_cycles <= cycles_next;
                    if (loop_seen) begin
                        o_done <= 1'b1;
                        o_ON   <= 1'b0;
                        o_busy <= 1'b0;
                        state  <= DONE;
                    end else if (budget_hit) begin
                        o_timeout <= 1'b1;
                        o_ON      <= 1'b0;
                        o_busy    <= 1'b0;
                        state     <= DONE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    o_byte_ready <= 1'b0;
                    o_we         <= 1'b0;
                    o_ON         <= 1'b0;
                    o_cpu_rst    <= 1'b0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Directed testbench for cpu_sequencer. Each scenario task drives its own
// stimulus and compares the outputs against expected values worked out by
// hand. A negedge monitor logs every write strobe and counts the o_ON and
// o_cpu_rst cycles.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort_r;
    logic [8:0]  length;
    logic [15:0] max_cycles;
    logic [7:0]  byte_d;
    logic        byte_valid;
    logic        byte_ready;
    logic        loopf;
    logic [7:0]  instr_addr;
    logic [15:0] instr;
    logic        we;
    logic        on_r;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycles;

    int checks;
    int failures;
    int on_cnt;
    int rst_cnt;
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    cpu_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort_r),
        .i_length     (length),
        .i_max_cycles (max_cycles),
        .i_byte       (byte_d),
        .i_byte_valid (byte_valid),
        .o_byte_ready (byte_ready),
        .i_loopf      (loopf),
        .o_instr_addr (instr_addr),
        .o_instr      (instr),
        .o_we         (we),
        .o_ON         (on_r),
        .o_cpu_rst    (cpu_rst),
        .o_busy       (busy),
        .o_done       (done),
        .o_timeout    (timeout),
        .o_cycles     (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log write strobes and count run / reset cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (we) begin
            wr_addr.push_back(instr_addr);
            wr_data.push_back(instr);
        end
        if (on_r)    on_cnt  = on_cnt + 1;
        if (cpu_rst) rst_cnt = rst_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        on_cnt  = 0;
        rst_cnt = 0;
    endtask

    task automatic do_start(input logic [8:0] len, input logic [15:0] budget);
        length     = len;
        max_cycles = budget;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Offer one byte and hold it until a handshake edge passes.
    task automatic send_byte(input logic [7:0] b);
        logic taken;
        taken      = 1'b0;
        byte_d     = b;
        byte_valid = 1'b1;
        for (int k = 0; k < 50 && !taken; k++) begin
            taken = byte_ready;
            tick();
        end
        byte_valid = 1'b0;
        checks++;
        if (!taken) begin
            failures++;
            $display("[TB] FAIL byte_handshake got=no_accept want=accept byte=%02h", b);
        end
    endtask

    task automatic wait_on();
        logic seen;
        seen = on_r;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            seen = on_r;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL wait_on got=0 want=1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({byte_ready, we, on_r, cpu_rst, busy, done, timeout} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%07b want=0000000",
                     {byte_ready, we, on_r, cpu_rst, busy, done, timeout});
        end
        checks++;
        if (instr_addr !== 8'h00 || instr !== 16'h0000 || cycles !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_regs got=%02h/%04h/%0d want=00/0000/0",
                     instr_addr, instr, cycles);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        clear_logs();
        do_start(9'd2, 16'd0);
        checks++;
        if (byte_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL normal_loadhi got=rdy%0b/busy%0b want=1/1", byte_ready, busy);
        end
        send_byte(8'h10);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_on();
        tick();
        tick();
        loopf = 1'b1;
        tick();
        loopf = 1'b0;
        checks++;
        if (done !== 1'b1 || timeout !== 1'b0 || on_r !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL normal_end got=d%0b/t%0b/on%0b/b%0b want=1/0/0/0",
                     done, timeout, on_r, busy);
        end
        checks++;
        if (cycles !== 16'd3 || on_cnt != 3) begin
            failures++;
            $display("[TB] FAIL normal_cycles got=%0d/on%0d want=3/3", cycles, on_cnt);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            failures++;
            $display("[TB] FAIL normal_wr_count got=%0d want=2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 16'h1005 ||
                wr_addr[1] !== 8'd1 || wr_data[1] !== 16'h0000) begin
                failures++;
                $display("[TB] FAIL normal_wr_data got=%02h:%04h,%02h:%04h want=00:1005,01:0000",
                         wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if (rst_cnt != 1) begin
            failures++;
            $display("[TB] FAIL normal_cpu_rst got=%0d want=1", rst_cnt);
        end
    endtask

    task automatic test_stall();
        clear_logs();
        do_start(9'd1, 16'd0);
        send_byte(8'hAB);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (we !== 1'b0 || byte_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stall_hold got=we%0b/rdy%0b want=0/1 cycle=%0d", we, byte_ready, k);
            end
        end
        send_byte(8'hCD);
        wait_on();
        checks++;
        if (wr_addr.size() != 1) begin
            failures++;
            $display("[TB] FAIL stall_wr_count got=%0d want=1", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 16'hABCD) begin
                failures++;
                $display("[TB] FAIL stall_wr_data got=%02h:%04h want=00:abcd", wr_addr[0], wr_data[0]);
            end
        end
        // loopf raised in the settle cycle is ignored; taken one cycle later.
        loopf = 1'b1;
        tick();
        checks++;
        if (on_r !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL settle_ignore got=on%0b/d%0b want=1/0", on_r, done);
        end
        tick();
        loopf = 1'b0;
        checks++;
        if (done !== 1'b1 || cycles !== 16'd2) begin
            failures++;
            $display("[TB] FAIL settle_done got=d%0b/c%0d want=1/2", done, cycles);
        end
    endtask

    task automatic test_budget();
        clear_logs();
        do_start(9'd0, 16'd4);
        checks++;
        if (on_r !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++;
            $display("[TB] FAIL len0_clear got=on%0b/rst%0b want=0/1", on_r, cpu_rst);
        end
        tick();
        checks++;
        if (on_r !== 1'b1 || cpu_rst !== 1'b0) begin
            failures++;
            $display("[TB] FAIL len0_latency got=on%0b/rst%0b want=1/0", on_r, cpu_rst);
        end
        for (int k = 0; k < 20 && on_r; k++) tick();
        checks++;
        if (timeout !== 1'b1 || done !== 1'b0 || cycles !== 16'd4 || on_cnt != 4) begin
            failures++;
            $display("[TB] FAIL budget_timeout got=t%0b/d%0b/c%0d/on%0d want=1/0/4/4",
                     timeout, done, cycles, on_cnt);
        end
        checks++;
        if (wr_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL len0_no_write got=%0d want=0", wr_addr.size());
        end
    endtask

    task automatic test_tie();
        do_start(9'd0, 16'd4);
        wait_on();
        tick();
        tick();
        tick();
        loopf = 1'b1;
        tick();
        loopf = 1'b0;
        checks++;
        if (done !== 1'b1 || timeout !== 1'b0 || cycles !== 16'd4 || on_r !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_done got=d%0b/t%0b/c%0d/on%0b want=1/0/4/0",
                     done, timeout, cycles, on_r);
        end
    endtask

    task automatic test_len256();
        int bad;
        clear_logs();
        do_start(9'd256, 16'd1);
        for (int i = 0; i < 256; i++) begin
            send_byte(~i[7:0]);
            send_byte(i[7:0]);
        end
        wait_on();
        tick();
        checks++;
        if (wr_addr.size() != 256) begin
            failures++;
            $display("[TB] FAIL len256_count got=%0d want=256", wr_addr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                if (wr_addr[i] !== i[7:0] || wr_data[i] !== {~i[7:0], i[7:0]}) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("[TB] FAIL len256_data got=%0d_bad_words want=0", bad);
            end
        end
        checks++;
        if (rst_cnt != 1 || timeout !== 1'b1 || cycles !== 16'd1) begin
            failures++;
            $display("[TB] FAIL len256_run got=rst%0d/t%0b/c%0d want=1/1/1", rst_cnt, timeout, cycles);
        end
    endtask

    task automatic test_abort();
        // Abort from DONE clears the sticky done flag left by test_tie.
        abort_r = 1'b1;
        tick();
        abort_r = 1'b0;
        checks++;
        if (done !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_done got=d%0b/t%0b want=0/0", done, timeout);
        end
        do_start(9'd2, 16'd0);
        send_byte(8'h55);
        abort_r = 1'b1;
        tick();
        abort_r = 1'b0;
        checks++;
        if ({byte_ready, we, on_r, cpu_rst, busy, done, timeout} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL abort_loadlo got=%07b want=0000000",
                     {byte_ready, we, on_r, cpu_rst, busy, done, timeout});
        end
        do_start(9'd0, 16'd0);
        wait_on();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (on_r !== 1'b1 || busy !== 1'b1 || cycles !== 16'd2 || cpu_rst !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_ignored got=on%0b/b%0b/c%0d/rst%0b want=1/1/2/0",
                     on_r, busy, cycles, cpu_rst);
        end
        abort_r = 1'b1;
        tick();
        abort_r = 1'b0;
        checks++;
        if ({byte_ready, we, on_r, cpu_rst, busy, done, timeout} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL abort_run got=%07b want=0000000",
                     {byte_ready, we, on_r, cpu_rst, busy, done, timeout});
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(9'd0, 16'd0);
        wait_on();
        tick();
        tick();
        rst = 1'b1;
        #2;
        checks++;
        if (on_r !== 1'b0 || busy !== 1'b0 || cycles !== 16'd0 || instr !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL async_reset got=on%0b/b%0b/c%0d/i%04h want=0/0/0/0000",
                     on_r, busy, cycles, instr);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        on_cnt     = 0;
        rst_cnt    = 0;
        rst        = 1'b0;
        start      = 1'b0;
        abort_r    = 1'b0;
        length     = '0;
        max_cycles = '0;
        byte_d     = '0;
        byte_valid = 1'b0;
        loopf      = 1'b0;
        #2;
        test_reset();
        test_normal();
        test_stall();
        test_budget();
        test_tie();
        test_abort();
        test_len256();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Host-side controller for the FRANK6000 CPU core. It accepts a program as a byte stream over a valid/ready handshake and packs the bytes into 16-bit instruction words. It writes the words sequentially into the CPU instruction memory, pulses the CPU reset, then runs the CPU until it signals its halt loop or a cycle budget expires. It drives the CPU's load and run inputs (`i_instr_addr`, `i_instr`, `i_we`, `i_ON`, `i_rst`) and observes its `o_loopf`.

## Interface
- `ADDR_WIDTH`, 8: instruction memory address width.
- `DATA_WIDTH`, 16: instruction width. Fixed at two bytes.
- `CNT_WIDTH`, 16: width of the run-cycle counter and of the budget.
- `i_clk`  in  1  clock. All logic is on the rising edge, one clock domain.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  begins a load-and-run sequence. Honoured only in IDLE or DONE.
- `i_abort`  in  1  forces IDLE from any state. Has priority over `i_start`.
- `i_length`  in  ADDR_WIDTH+1  number of words to load, 0..256. Latched on an accepted start.
- `i_max_cycles`  in  CNT_WIDTH  run budget. Latched on an accepted start. 0 means no timeout.
- `i_byte`  in  8  program byte.
- `i_byte_valid`  in  1  `i_byte` is valid.
- `o_byte_ready`  out  1  sequencer can accept a byte.
- `i_loopf`  in  1  CPU halt-loop flag.
- `o_instr_addr`  out  ADDR_WIDTH  instruction memory write address.
- `o_instr`  out  DATA_WIDTH  instruction memory write data.
- `o_we`  out  1  instruction memory write enable.
- `o_ON`  out  1  CPU run enable.
- `o_cpu_rst`  out  1  CPU reset pulse.
- `o_busy`  out  1  high in every state except IDLE and DONE.
- `o_done`  out  1  the run ended on `i_loopf`. Sticky until the next start or abort.
- `o_timeout`  out  1  the run ended on the budget. Sticky until the next start or abort.
- `o_cycles`  out  CNT_WIDTH  number of RUN cycles elapsed.

## Operation
States: IDLE, LOAD_HI, LOAD_LO, WRITE, CLEAR, RUN, DONE. All outputs are registered.

**IDLE / DONE, on `i_start`:**
- Latch `i_length` and `i_max_cycles`.
- Clear `o_done`, `o_timeout`, `o_cycles` and the write pointer.
- Go to LOAD_HI, or to CLEAR if `i_length`==0. A zero length reruns the program already in memory.

**LOAD_HI:**
- `o_byte_ready`=1.
- On `i_byte_valid`, store the byte as `o_instr[15:8]` and go to LOAD_LO.

**LOAD_LO:**
- `o_byte_ready`=1.
- On `i_byte_valid`, store the byte as `o_instr[7:0]` and go to WRITE. Byte order is big-endian.

**WRITE:**
- `o_we`=1 for exactly one cycle, with `o_instr_addr` = the pointer.
- Next, the pointer increments.
- If words written == length, go to CLEAR; otherwise go to LOAD_HI.
- Length 256 fills the whole memory. The 8-bit pointer wraps to 0 after the last write, but the word count is 9 bits, so termination is still correct.

**CLEAR:**
- `o_cpu_rst`=1 and `o_ON`=0 for one cycle, so the CPU PC, WREG, ADDR and STATUS start from zero.
- Go to RUN.

**RUN:**
- `o_ON`=1 and `o_cycles` increments each cycle.
- `i_loopf` is ignored while `o_cycles`==0, the fetch-settle cycle.
- `i_loopf`=1 → set `o_done`, go to DONE.
- `o_cycles`+1 == budget (budget ≠ 0) → set `o_timeout`, go to DONE.
- If both happen in the same cycle, done wins: `o_timeout` stays 0.
- With budget 0, the counter saturates at all-ones and the CPU runs until loopf or abort.

**DONE:**
- `o_ON`=0, which freezes the CPU. The CPU WREG output stays readable by the host.
- `o_cycles` holds its final value.

**Ignored and abort events:**
- `i_start` is ignored while `o_busy`=1.
- `i_abort` returns to IDLE in one cycle from any state. It drops `o_ON`, `o_we`, `o_byte_ready`, `o_busy` and clears `o_done`/`o_timeout`.
- A partially loaded program stays in memory as written.

## Timing
- **Reset values:** `o_instr_addr`=0, `o_instr`=0, `o_we`=0, `o_ON`=0, `o_cpu_rst`=0, `o_byte_ready`=0, `o_busy`=0, `o_done`=0, `o_timeout`=0, `o_cycles`=0, state IDLE.
- **Reset mid-operation:** behaves like abort, applied immediately.
- **Byte handshake:** a byte transfers on a rising edge where `i_byte_valid` & `o_byte_ready`. `i_byte` must be stable while valid is high. The source may stall indefinitely. Bytes offered outside LOAD_* are not accepted.
- **Load throughput:** with back-to-back bytes, one word per 3 cycles. N words take 3N cycles from the first LOAD_HI.
- **Start-to-run latency:** for length N, `o_ON` first rises 3N+2 cycles after the start edge. The start edge itself takes one cycle to enter LOAD_HI.
- **Run end:**
  - `o_ON` falls in the cycle after the edge that samples loopf or the last budget cycle.
  - `o_done`/`o_timeout` rise in that same cycle.
  - `o_cycles` equals the number of cycles `o_ON` was high.

## Test plan
- **Normal load and run:** reset, start with length 2, bytes 0x10,0x05,0x00,0x00.
  - Expect `o_we` pulses at addr 0 with data 0x1005, then at addr 1 with 0x0000.
  - Expect one `o_cpu_rst` cycle, then `o_ON`.
  - With loopf asserted on RUN cycle 2: `o_done`=1, `o_timeout`=0, `o_cycles`=3.
- **Stalled source:** drop valid for 5 cycles between the bytes of a word.
  - Expect no write until the low byte arrives.
  - Expect `o_byte_ready` held high throughout; data still correct.
- **Budget and ties:** with budget 4 and loopf never asserted, expect `o_timeout`=1 after exactly 4 `o_ON` cycles, `o_cycles`=4.
  - Repeat with loopf on the 4th cycle: expect `o_done`=1, `o_timeout`=0.
- **Boundary lengths:** length 0 → no `o_we`, and `o_ON` rises 2 cycles after start.
  - Length 256 → 256 writes at addresses 0..255, then CLEAR.
- **Abort, reset, ignored start:** abort in LOAD_LO and in RUN → IDLE next cycle with all outputs low.
  - Async reset asserted mid-RUN → all outputs at reset values without a clock edge.
  - `i_start` pulsed during RUN is ignored.
